// File: rtl/mem_c_deskew.sv
// mem_c_deskew: realigns the skewed C outputs of the systolic array so that
// each full C row leaves on a single cycle.
//
// Input lane j carries row r at en-cycle r+j after start, where the start
// cycle is en-cycle 0. Lane j is delayed by DIM-1-j stages and then goes
// through the common Cout register. Every lane therefore sees DIM-j
// en-advances, and row r reaches Cout aligned at en-cycle DIM+r.
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   en          - advance enable; every register holds while en=0
//   start       - lane 0 carries row 0 this cycle (sampled only when en=1)
//   Cin         - skewed lane inputs, DIM lanes of BITS_C bits
//   Cout        - aligned row, registered
//   vld_out     - Cout holds a new aligned row this cycle (0 while stalled)
//   row_idx     - index of the row on Cout
//   busy        - a matrix deskew is in progress
//   done        - one-cycle pulse that comes with vld_out for row DIM-1

// Per-lane delay line of DEPTH en-gated stages (DEPTH may be 0).
module mem_c_deskew_lane #(
    parameter int W     = 24,
    parameter int DEPTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_pass
        assign q = d;
    end else begin : g_dly
        logic [DEPTH-1:0][W-1:0] sr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sr <= '0;
            end else if (en) begin
                sr[0] <= d;
                for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[DEPTH-1];
    end
endmodule

module mem_c_deskew #(
    parameter int BITS_C = 24,
    parameter int DIM    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                start,
    input  logic signed [DIM-1:0][BITS_C-1:0]   Cin,
    output logic signed [DIM-1:0][BITS_C-1:0]   Cout,
    output logic                                vld_out,
    output logic [(DIM > 1 ? $clog2(DIM) : 1)-1:0] row_idx,
    output logic                                busy,
    output logic                                done
);
    localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CW = $clog2(2 * DIM);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                     state;
    logic [CW-1:0]              cnt;
    logic                       vld_q, done_q;
    logic [RW-1:0]              row_q;
    logic [DIM-1:0][BITS_C-1:0] lane_q;

    for (genvar j = 0; j < DIM; j++) begin : g_lane
        mem_c_deskew_lane #(.W(BITS_C), .DEPTH(DIM - 1 - j)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .d     (Cin[j]),
            .q     (lane_q[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) Cout <= '0;
        else if (en) Cout <= lane_q;
    end

    // cnt is the en-cycle index since start. The start cycle is index 0 and
    // the FSM is still IDLE then, so the registered count leaves IDLE at 1.
    // Rows are registered at indices DIM-1 .. 2*DIM-2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            row_q  <= '0;
            busy   <= 1'b0;
        end else if (en) begin
            vld_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= CW'(1);
                        if (DIM == 1) begin
                            // The start cycle is already the only drain cycle.
                            vld_q  <= 1'b1;
                            done_q <= 1'b1;
                            row_q  <= '0;
                            cnt    <= '0;
                        end else if (DIM == 2) begin
                            state <= DRAIN;
                            busy  <= 1'b1;
                        end else begin
                            state <= FILL;
                            busy  <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(DIM - 2)) state <= DRAIN;
                end
                DRAIN: begin
                    vld_q <= 1'b1;
                    row_q <= RW'(cnt - CW'(DIM - 1));
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(2 * DIM - 2)) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                        cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A stalled cycle never presents a row. The row held in the register is
    // presented on the next cycle that has en=1.
    assign vld_out = vld_q & en;
    assign done    = done_q & en;
    assign row_idx = row_q;
endmodule

// File: tb/tb_mem_c_deskew.sv
module tb_mem_c_deskew;
    localparam int DIM    = 4;
    localparam int BW     = 16;
    localparam int K_LAST = 2 * DIM - 1;

    logic clk = 1'b0;
    logic rst_n, en, start;
    logic signed [DIM-1:0][BW-1:0] Cin;
    logic signed [DIM-1:0][BW-1:0] Cout;
    logic vld_out, busy, done;
    logic [1:0] row_idx;

    mem_c_deskew #(.BITS_C(BW), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .Cin(Cin),
        .Cout(Cout), .vld_out(vld_out), .row_idx(row_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Reference model: each slot is a matrix in flight. mk is its en-cycle
    // index since start, or -1 when the slot is free. Row r is presented in
    // the en=1 cycle whose index is DIM+r.
    int          mk [2];
    logic [BW-1:0] mat [2][DIM][DIM];
    logic [BW-1:0] next_mat [DIM][DIM];

    task automatic cycle(input bit en_i, input bit st_i);
        bit busy_m, acc, vld_m, done_m;
        int row_m, sl;
        logic [DIM-1:0][BW-1:0] exp_c;
        @(negedge clk);
        cyc++;
        busy_m = 0;
        for (int s = 0; s < 2; s++) if (mk[s] >= 1 && mk[s] <= K_LAST - 1) busy_m = 1;
        acc = en_i && st_i && !busy_m;
        if (acc) begin
            sl = 0;
            for (int s = 1; s >= 0; s--) if (mk[s] < 0) sl = s;
            mk[sl] = 0;
            for (int r = 0; r < DIM; r++)
                for (int j = 0; j < DIM; j++) mat[sl][r][j] = next_mat[r][j];
        end
        en = en_i;
        start = st_i;
        for (int j = 0; j < DIM; j++) begin
            Cin[j] = BW'($urandom);
            for (int s = 0; s < 2; s++)
                if (mk[s] >= 0 && mk[s] - j >= 0 && mk[s] - j < DIM)
                    Cin[j] = mat[s][mk[s]-j][j];
        end
        vld_m = 0; done_m = 0; row_m = 0; exp_c = '0;
        for (int s = 0; s < 2; s++)
            if (en_i && mk[s] >= DIM && mk[s] <= K_LAST) begin
                vld_m  = 1;
                row_m  = mk[s] - DIM;
                done_m = (mk[s] == K_LAST);
                for (int j = 0; j < DIM; j++) exp_c[j] = mat[s][row_m][j];
            end
        #1;
        nvec++;
        if (vld_out !== vld_m) begin
            nerr++; $display("FAIL vld_out cyc=%0d got %b want %b", cyc, vld_out, vld_m);
        end
        nvec++;
        if (done !== done_m) begin
            nerr++; $display("FAIL done cyc=%0d got %b want %b", cyc, done, done_m);
        end
        nvec++;
        if (busy !== busy_m) begin
            nerr++; $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, busy_m);
        end
        if (vld_m) begin
            nvec++;
            if (row_idx !== 2'(row_m)) begin
                nerr++; $display("FAIL row_idx cyc=%0d got %0d want %0d", cyc, row_idx, row_m);
            end
            nvec++;
            if (Cout !== exp_c) begin
                nerr++; $display("FAIL cout cyc=%0d got %h want %h", cyc, Cout, exp_c);
            end
        end
        if (en_i)
            for (int s = 0; s < 2; s++)
                if (mk[s] >= 0) begin
                    mk[s]++;
                    if (mk[s] > K_LAST) mk[s] = -1;
                end
    endtask

    task automatic fill_pattern(input int sgn);
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) next_mat[r][j] = BW'(sgn * (16 * r + j));
    endtask

    task automatic fill_random();
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++) next_mat[r][j] = BW'($urandom);
    endtask

    task automatic settle();
        repeat (K_LAST + 2) cycle(1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; start = 1'b0; Cin = '0;
        mk[0] = -1; mk[1] = -1;
        #12;
        nvec++;
        if ({Cout, vld_out, row_idx, busy, done} !== '0) begin
            nerr++; $display("FAIL reset_state got %h want 0", {Cout, vld_out, row_idx, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        fill_pattern(1);
        cycle(1'b1, 1'b1);
        repeat (9) cycle(1'b1, 1'b0);
    endtask

    task automatic test_stall();
        fill_pattern(1);
        cycle(1'b1, 1'b1);
        repeat (5) cycle(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0);
        repeat (6) cycle(1'b1, 1'b0);
    endtask

    task automatic test_signed();
        for (int r = 0; r < DIM; r++)
            for (int j = 0; j < DIM; j++)
                next_mat[r][j] = ((r + j) % 2) ? 16'h7fff : 16'h8000;
        cycle(1'b1, 1'b1);
        settle();
    endtask

    task automatic test_busy_start();
        fill_pattern(1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        fill_random();
        cycle(1'b1, 1'b1);
        settle();
    endtask

    task automatic test_start_no_en();
        fill_pattern(1);
        cycle(1'b0, 1'b1);
        settle();
    endtask

    task automatic test_back_to_back();
        fill_pattern(1);
        cycle(1'b1, 1'b1);
        repeat (6) cycle(1'b1, 1'b0);
        fill_pattern(-1);
        cycle(1'b1, 1'b1);
        settle();
    endtask

    task automatic test_mid_reset();
        fill_pattern(1);
        cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({Cout, vld_out, row_idx, busy, done} !== '0) begin
            nerr++; $display("FAIL mid_reset got %h want 0", {Cout, vld_out, row_idx, busy, done});
        end
        mk[0] = -1; mk[1] = -1;
        #2;
        rst_n = 1'b1;
        repeat (4) cycle(1'b1, 1'b0);
        fill_random();
        cycle(1'b1, 1'b1);
        settle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            fill_random();
            cycle(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2));
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_signed();
        test_busy_start();
        test_start_no_en();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
